hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-specifier width.
REQ-002 Parameter LOAD_STALL, default 1, range 1..3, bubbles inserted per load-use hazard.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  ADDR_W  source specifiers of the instruction in IF/ID.
REQ-006 id_uses_rt  in  1  the IF/ID instruction reads rt.
REQ-007 idex_rd, idex_regwrite, idex_memread  in  ADDR_W,1,1  destination, write enable and load flag of the ID/EX instruction.
REQ-008 exmem_rd, exmem_regwrite  in  ADDR_W,1  destination and write enable of the EX/MEM instruction.
REQ-009 memwb_rd, memwb_regwrite  in  ADDR_W,1  destination and write enable of the MEM/WB instruction.
REQ-010 flush  in  1  synchronous branch/jump flush.
REQ-011 fwd_a, fwd_b  out  2  registered operand-select for the instruction in EX: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB bypass.
REQ-012 pc_write, ifid_write  out  1  PC and IF/ID write enables.
REQ-013 idex_bubble  out  1  load a bubble into ID/EX on this edge.
REQ-014 stall_busy  out  1  FSM is in STALL.

Function
REQ-015 hazard = idex_memread & idex_regwrite & (idex_rd!=0) & ((idex_rd==id_rs) | (id_uses_rt & idex_rd==id_rt)), evaluated only in state RUN.
REQ-016 stall = ~flush & (hazard | state==STALL); pc_write = ifid_write = ~stall; idex_bubble = stall | flush (combinational).
REQ-017 FSM states RUN, STALL; counter width 2.
REQ-018 RUN, hazard, LOAD_STALL==1: remain RUN (single bubble this cycle).
REQ-019 RUN, hazard, LOAD_STALL>1: go STALL, cnt <= LOAD_STALL-1.
REQ-020 STALL: cnt decrements each edge; when cnt==1, return to RUN on that edge.
REQ-021 flush=1 at an edge: state <= RUN, cnt <= 0, fwd_a/fwd_b <= 00; flush overrides hazard and STALL in the same cycle.
REQ-022 Forward selects precomputed at the edge the IF/ID instruction enters EX; for operand X (rs for fwd_a, rt for fwd_b), priority order:
REQ-023   10 if idex_regwrite & ~idex_memread & idex_rd!=0 & idex_rd==X;
REQ-024   else 01 if exmem_regwrite & exmem_rd!=0 & exmem_rd==X;
REQ-025   else 11 if WB_BYPASS_EN defined & memwb_regwrite & memwb_rd!=0 & memwb_rd==X;
REQ-026   else 00.
REQ-027 fwd_b evaluated from id_rt regardless of id_uses_rt.
REQ-028 At an edge with idex_bubble=1, fwd_a/fwd_b <= 00 (bubble in EX).
REQ-029 Register 0 never matches; ADDR_W comparisons full width, no truncation.

Reset
REQ-030 reset_n=0 asynchronously forces state RUN, cnt 0, fwd_a=fwd_b=00, stall_busy=0.
REQ-031 During reset pc_write, ifid_write, idex_bubble follow REQ-016 with state RUN (no hazard inputs -> 1,1,0).
REQ-032 Reset asserted mid-STALL abandons the stall; first edge after release evaluates hazard fresh.

Configuration
REQ-033 Macro WB_BYPASS_EN: defined -> REQ-025 active, code 11 generated; undefined -> MEM/WB matches ignored, code 11 never produced (regfile handles write-before-read).

Verification
REQ-034 LOAD_STALL=1: idex load rd=5, id_rs=5 -> one cycle pc_write=0, idex_bubble=1; next edge fwd_a=01.
REQ-035 LOAD_STALL=3: load rd=8, id_rt=8, id_uses_rt=1 -> pc_write low exactly 3 cycles, stall_busy high 2 cycles.
REQ-036 idex ALU rd=3 and exmem rd=3, id_rs=3 -> fwd_a=10 (EX/MEM priority); idex_rd=0, id_rs=0 -> fwd_a=00.
REQ-037 WB_BYPASS_EN defined, memwb rd=7 only, id_rt=7 -> fwd_b=11; undefined -> fwd_b=00.
REQ-038 flush=1 in second cycle of LOAD_STALL=2 stall -> pc_write=1 same cycle, state RUN, fwd 00 next edge.
REQ-039 reset_n low mid-STALL -> stall_busy=0, fwd 00 immediately (asynchronously).

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage pipeline.
// A load in ID/EX whose destination is read by the IF/ID instruction stalls
// PC and IF/ID for LOAD_STALL cycles and injects bubbles into ID/EX.
// Operand selects for EX are precomputed one stage early and registered.
// Optional feature macro: WB_BYPASS_EN enables the MEM/WB bypass select (11).
module hazard_forward_unit #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned LOAD_STALL = 1
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_uses_rt_i,
   input  logic [ADDR_W-1:0] idex_rd_i,
   input  logic              idex_regwrite_i,
   input  logic              idex_memread_i,
   input  logic [ADDR_W-1:0] exmem_rd_i,
   input  logic              exmem_regwrite_i,
   input  logic [ADDR_W-1:0] memwb_rd_i,
   input  logic              memwb_regwrite_i,
   input  logic              flush_i,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              idex_bubble_o,
   output logic              stall_busy_o
);

   typedef enum logic [0:0] {
      StRun,
      StStall
   } state_e;

   // Operand-select encodings for the EX-stage muxes.
   localparam logic [1:0] SelRegfile = 2'b00;
   localparam logic [1:0] SelExMem   = 2'b10;
   localparam logic [1:0] SelMemWb   = 2'b01;
`ifdef WB_BYPASS_EN
   localparam logic [1:0] SelWbByp   = 2'b11;
`endif

   // Extra stall cycles spent in StStall after the detecting cycle.
   localparam logic [1:0] StallInit = 2'(LOAD_STALL - 1);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] fwd_a_q, fwd_a_d;
   logic [1:0] fwd_b_q, fwd_b_d;

   logic hazard;
   logic stall;
   logic bubble;

`ifndef WB_BYPASS_EN
   // Without the bypass the register file resolves write-before-read itself.
   logic unused_memwb;
   assign unused_memwb = ^{memwb_rd_i, memwb_regwrite_i};
`endif

   // The ID/EX instruction reaches EX/MEM and the EX/MEM one reaches MEM/WB
   // by the time the IF/ID instruction is in EX, hence the stage naming.
   function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = SelRegfile;
      if (idex_regwrite_i && !idex_memread_i && (idex_rd_i != '0) && (idex_rd_i == src)) begin
         sel = SelExMem;
      end else if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src)) begin
         sel = SelMemWb;
      end
`ifdef WB_BYPASS_EN
      else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src)) begin
         sel = SelWbByp;
      end
`endif
      return sel;
   endfunction

   // Hazard detection and pipeline-control outputs.
   always_comb begin
      hazard = (state_q == StRun) && idex_memread_i && idex_regwrite_i &&
               (idex_rd_i != '0) &&
               ((idex_rd_i == id_rs_i) || (id_uses_rt_i && (idex_rd_i == id_rt_i)));
      stall  = !flush_i && (hazard || (state_q == StStall));
      bubble = stall || flush_i;
   end

   assign pc_write_o    = !stall;
   assign ifid_write_o  = !stall;
   assign idex_bubble_o = bubble;
   assign stall_busy_o  = (state_q == StStall);
   assign fwd_a_o       = fwd_a_q;
   assign fwd_b_o       = fwd_b_q;

   // Stall FSM next state; flush wins over both hazard and an ongoing stall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = StRun;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hazard && (LOAD_STALL > 1)) begin
                  state_d = StStall;
                  cnt_d   = StallInit;
               end
            end
            StStall: begin
               // cnt of 0 cannot occur here, but leave rather than wedge.
               if (cnt_q <= 2'd1) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: begin
               state_d = StRun;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Forward selects for the instruction entering EX; a bubble reads regfile.
   always_comb begin
      fwd_a_d = SelRegfile;
      fwd_b_d = SelRegfile;
      if (!bubble) begin
         fwd_a_d = fwd_sel(id_rs_i);
         fwd_b_d = fwd_sel(id_rt_i);
      end
   end

   // State, counter and registered forward selects.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StRun;
         cnt_q   <= '0;
         fwd_a_q <= SelRegfile;
         fwd_b_q <= SelRegfile;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three instances (LOAD_STALL = 1, 2, 3) share
// one stimulus stream; expectations are queued at drive time and popped when
// the outputs are sampled.
module tb_hazard_forward_unit;

   localparam int AW = 5;

`ifdef WB_BYPASS_EN
   localparam logic [1:0] WbSel = 2'b11;
`else
   localparam logic [1:0] WbSel = 2'b00;
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic [AW-1:0] id_rs, id_rt, idex_rd, exmem_rd, memwb_rd;
   logic          id_uses_rt, idex_regwrite, idex_memread;
   logic          exmem_regwrite, memwb_regwrite, flush;

   logic [1:0] fa [3];
   logic [1:0] fb [3];
   logic       pw [3];
   logic       iw [3];
   logic       bb [3];
   logic       sb [3];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_forward_unit #(
         .ADDR_W    (AW),
         .LOAD_STALL(g + 1)
      ) u_dut (
         .clock_i         (clock),
         .reset_ni        (reset_n),
         .id_rs_i         (id_rs),
         .id_rt_i         (id_rt),
         .id_uses_rt_i    (id_uses_rt),
         .idex_rd_i       (idex_rd),
         .idex_regwrite_i (idex_regwrite),
         .idex_memread_i  (idex_memread),
         .exmem_rd_i      (exmem_rd),
         .exmem_regwrite_i(exmem_regwrite),
         .memwb_rd_i      (memwb_rd),
         .memwb_regwrite_i(memwb_regwrite),
         .flush_i         (flush),
         .fwd_a_o         (fa[g]),
         .fwd_b_o         (fb[g]),
         .pc_write_o      (pw[g]),
         .ifid_write_o    (iw[g]),
         .idex_bubble_o   (bb[g]),
         .stall_busy_o    (sb[g])
      );
   end

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic push(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag, input logic [7:0] obs);
      exp_t e;
      n_chk++;
      if (sb_q.size() == 0) begin
         $error("FAIL %s scoreboard empty, observed=%02h", tag, obs);
         return;
      end
      e = sb_q.pop_front();
      assert (obs === e.val && tag == e.tag) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h (queued %s)", tag, obs, e.val, e.tag);
   endtask

   // Combinational expectation per instance: {pc_write, idex_bubble, stall_busy}.
   task automatic exp_c(input string tag, input logic [2:0] d1, input logic [2:0] d2,
                        input logic [2:0] d3);
      push($sformatf("%s/c1", tag), {4'b0, d1[2], d1[2], d1[1], d1[0]});
      push($sformatf("%s/c2", tag), {4'b0, d2[2], d2[2], d2[1], d2[0]});
      push($sformatf("%s/c3", tag), {4'b0, d3[2], d3[2], d3[1], d3[0]});
   endtask

   // Post-edge expectation per instance: {fwd_a, fwd_b, stall_busy}.
   task automatic exp_r(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3);
      push($sformatf("%s/r1", tag), {3'b0, r1});
      push($sformatf("%s/r2", tag), {3'b0, r2});
      push($sformatf("%s/r3", tag), {3'b0, r3});
   endtask

   task automatic cmp_c(input string tag);
      for (int g = 0; g < 3; g++) begin
         pop_cmp($sformatf("%s/c%0d", tag, g + 1), {4'b0, pw[g], iw[g], bb[g], sb[g]});
      end
   endtask

   task automatic cmp_r(input string tag);
      for (int g = 0; g < 3; g++) begin
         pop_cmp($sformatf("%s/r%0d", tag, g + 1), {3'b0, fa[g], fb[g], sb[g]});
      end
   endtask

   // Inputs are already driven (after a negedge); check comb, clock, check regs.
   task automatic step(input string tag,
                       input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3);
      exp_c(tag, c1, c2, c3);
      exp_r(tag, r1, r2, r3);
      #1;
      cmp_c(tag);
      @(posedge clock);
      #1;
      cmp_r(tag);
   endtask

   task automatic clr();
      id_rs          = '0;
      id_rt          = '0;
      id_uses_rt     = 1'b0;
      idex_rd        = '0;
      idex_regwrite  = 1'b0;
      idex_memread   = 1'b0;
      exmem_rd       = '0;
      exmem_regwrite = 1'b0;
      memwb_rd       = '0;
      memwb_regwrite = 1'b0;
      flush          = 1'b0;
   endtask

   task automatic load(input logic [AW-1:0] rd);
      clr();
      idex_rd       = rd;
      idex_regwrite = 1'b1;
      idex_memread  = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      clr();
      #2;
      exp_c("rst", 3'b100, 3'b100, 3'b100);
      exp_r("rst", 5'b00000, 5'b00000, 5'b00000);
      cmp_c("rst");
      cmp_r("rst");
      @(negedge clock);
      reset_n = 1'b1;

      // EX/MEM select beats MEM/WB select
      @(negedge clock); clr();
      idex_rd = 5'd3; idex_regwrite = 1'b1; exmem_rd = 5'd3; exmem_regwrite = 1'b1;
      id_rs = 5'd3;
      step("exprio", 3'b100, 3'b100, 3'b100, 5'b10000, 5'b10000, 5'b10000);

      // register 0 never forwards
      @(negedge clock); clr();
      idex_regwrite = 1'b1; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      step("zero", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // fwd_b from rt even when rt is not read
      @(negedge clock); clr();
      idex_rd = 5'd6; idex_regwrite = 1'b1; id_rs = 5'd6;
      exmem_rd = 5'd4; exmem_regwrite = 1'b1; id_rt = 5'd4;
      step("memfwd", 3'b100, 3'b100, 3'b100, 5'b10010, 5'b10010, 5'b10010);

      // MEM/WB-only match
      @(negedge clock); clr();
      memwb_rd = 5'd7; memwb_regwrite = 1'b1; id_rt = 5'd7; id_rs = 5'd2;
      step("wbbyp", 3'b100, 3'b100, 3'b100, {2'b00, WbSel, 1'b0}, {2'b00, WbSel, 1'b0},
           {2'b00, WbSel, 1'b0});

      // full-width compares: specifiers differ only in the MSB
      @(negedge clock); clr();
      idex_rd = 5'd17; idex_regwrite = 1'b1; id_rs = 5'd1;
      exmem_rd = 5'd18; exmem_regwrite = 1'b1; id_rt = 5'd2;
      step("width", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // write enables low: no forwarding
      @(negedge clock); clr();
      idex_rd = 5'd3; exmem_rd = 5'd3; memwb_rd = 5'd3; id_rs = 5'd3; id_rt = 5'd3;
      step("nowen", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // loads that are not hazards: rd=0, no regwrite, rt not used
      @(negedge clock); load(5'd0); id_rs = 5'd0;
      step("ld_r0", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);
      @(negedge clock); load(5'd5); idex_regwrite = 1'b0; id_rs = 5'd5;
      step("ld_nowr", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);
      @(negedge clock); load(5'd8); id_rt = 5'd8; id_rs = 5'd1;
      step("ld_nort", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // load-use on rs, then the load sits in EX/MEM
      @(negedge clock); load(5'd5); id_rs = 5'd5;
      step("lu_rs0", 3'b010, 3'b010, 3'b010, 5'b00000, 5'b00001, 5'b00001);
      @(negedge clock); clr(); exmem_rd = 5'd5; exmem_regwrite = 1'b1; id_rs = 5'd5;
      step("lu_rs1", 3'b100, 3'b011, 3'b011, 5'b01000, 5'b00000, 5'b00001);
      step("lu_rs2", 3'b100, 3'b100, 3'b011, 5'b01000, 5'b01000, 5'b00000);
      step("lu_rs3", 3'b100, 3'b100, 3'b100, 5'b01000, 5'b01000, 5'b01000);

      // load-use on rt
      @(negedge clock); load(5'd8); id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd1;
      step("lu_rt0", 3'b010, 3'b010, 3'b010, 5'b00000, 5'b00001, 5'b00001);
      @(negedge clock); clr();
      step("lu_rt1", 3'b100, 3'b011, 3'b011, 5'b00000, 5'b00000, 5'b00001);
      step("lu_rt2", 3'b100, 3'b100, 3'b011, 5'b00000, 5'b00000, 5'b00000);
      step("lu_rt3", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // flush in the second stall cycle
      @(negedge clock); load(5'd5); id_rs = 5'd5;
      step("fl_0", 3'b010, 3'b010, 3'b010, 5'b00000, 5'b00001, 5'b00001);
      @(negedge clock); clr(); exmem_rd = 5'd5; exmem_regwrite = 1'b1; id_rs = 5'd5;
      flush = 1'b1;
      step("fl_1", 3'b110, 3'b111, 3'b111, 5'b00000, 5'b00000, 5'b00000);
      @(negedge clock); clr();
      step("fl_2", 3'b100, 3'b100, 3'b100, 5'b00000, 5'b00000, 5'b00000);

      // flush overrides a fresh hazard
      @(negedge clock); load(5'd5); id_rs = 5'd5; flush = 1'b1;
      step("fl_hz", 3'b110, 3'b110, 3'b110, 5'b00000, 5'b00000, 5'b00000);

      // reset in the middle of a stall
      @(negedge clock); load(5'd5); id_rs = 5'd5;
      step("rs_0", 3'b010, 3'b010, 3'b010, 5'b00000, 5'b00001, 5'b00001);
      @(negedge clock); clr(); exmem_rd = 5'd5; exmem_regwrite = 1'b1; id_rs = 5'd5;
      step("rs_1", 3'b100, 3'b011, 3'b011, 5'b01000, 5'b00000, 5'b00001);
      #1;
      reset_n = 1'b0;
      #1;
      exp_c("rs_mid", 3'b100, 3'b100, 3'b100);
      exp_r("rs_mid", 5'b00000, 5'b00000, 5'b00000);
      cmp_c("rs_mid");
      cmp_r("rs_mid");
      @(negedge clock);
      reset_n = 1'b1;
      load(5'd5); id_rs = 5'd5;
      step("rs_2", 3'b010, 3'b010, 3'b010, 5'b00000, 5'b00001, 5'b00001);
      @(negedge clock); clr();
      step("rs_3", 3'b100, 3'b011, 3'b011, 5'b00000, 5'b00000, 5'b00001);
      step("rs_4", 3'b100, 3'b100, 3'b011, 5'b00000, 5'b00000, 5'b00000);

      n_chk++;
      assert (sb_q.size() == 0) n_pass++;
      else $error("FAIL sb_drain observed=%0d expected=0 leftover entries", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
